// File: rtl/rfsoc_axis_pkg.sv
// Shared types and constants for the AXI-Stream channel router.
package rfsoc_axis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } rtr_state_t;

  localparam int DROP_CNT_W = 32;

endpackage

// File: rtl/axis_channel_router.sv
// Routes one AXI-Stream input to N_CH outputs by a per-packet mask; 1-cycle latency.
// Backpressure: upstream stalls while any selected sink has not taken the held beat.
module axis_channel_router
  import rfsoc_axis_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int N_CH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        channel_select,
  input  logic [DATA_W-1:0]      s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [DATA_W*N_CH-1:0] m_axis_tdata,
  output logic [N_CH-1:0]        m_axis_tvalid,
  output logic [N_CH-1:0]        m_axis_tlast,
  input  logic [N_CH-1:0]        m_axis_tready,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  rtr_state_t              state;
  logic [N_CH-1:0]         lock_mask;
  logic [N_CH-1:0]         pending;
  logic [DATA_W-1:0]       hold_data;
  logic                    hold_last;
  logic                    accept;
  logic [N_CH-1:0]         route_mask;

  // The held beat may be replaced in the same cycle its last pending sink takes it.
  assign s_axis_tready = ((pending & ~m_axis_tready) == '0);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign route_mask    = (state == IDLE) ? channel_select : lock_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lock_mask  <= '0;
      pending    <= '0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      drop_count <= '0;
    end else begin
      pending <= pending & ~m_axis_tready;
      if (accept) begin
        if (route_mask != '0) begin
          pending   <= route_mask;
          hold_data <= s_axis_tdata;
          hold_last <= s_axis_tlast;
        end else if (drop_count != '1) begin
          drop_count <= drop_count + 1'b1;
        end
        case (state)
          IDLE: begin
            lock_mask <= channel_select;
            if (!s_axis_tlast) state <= PKT;
          end
          PKT: begin
            if (s_axis_tlast) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign m_axis_tvalid = pending;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    assign m_axis_tdata[i*DATA_W +: DATA_W] = pending[i] ? hold_data : '0;
    assign m_axis_tlast[i]                  = pending[i] & hold_last;
  end

endmodule

// File: tb/tb_axis_channel_router.sv
// Directed checks on a 16-channel router plus a randomized scoreboard run on a 4-channel build.
module tb_axis_channel_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Directed DUT: N_CH=16, DATA_W=32
  logic         a_rst = 1'b1;
  logic [15:0]  a_sel = '0;
  logic [31:0]  a_s_tdata = '0;
  logic         a_s_tvalid = 1'b0;
  logic         a_s_tlast = 1'b0;
  logic         a_s_tready;
  logic [511:0] a_m_tdata;
  logic [15:0]  a_m_tvalid;
  logic [15:0]  a_m_tlast;
  logic [15:0]  a_m_tready = '1;
  logic [31:0]  a_drop;

  axis_channel_router #(.DATA_W(32), .N_CH(16)) u_dut_a (
    .clk(clk), .rst(a_rst), .channel_select(a_sel),
    .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tlast(a_s_tlast),
    .s_axis_tready(a_s_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tlast(a_m_tlast),
    .m_axis_tready(a_m_tready), .drop_count(a_drop)
  );

  // Random DUT: N_CH=4, DATA_W=64
  logic         r_rst = 1'b1;
  logic [3:0]   r_sel = '0;
  logic [63:0]  r_s_tdata = '0;
  logic         r_s_tvalid = 1'b0;
  logic         r_s_tlast = 1'b0;
  logic         r_s_tready;
  logic [255:0] r_m_tdata;
  logic [3:0]   r_m_tvalid;
  logic [3:0]   r_m_tlast;
  logic [3:0]   r_m_tready = '1;
  logic [31:0]  r_drop;

  axis_channel_router #(.DATA_W(64), .N_CH(4)) u_dut_r (
    .clk(clk), .rst(r_rst), .channel_select(r_sel),
    .s_axis_tdata(r_s_tdata), .s_axis_tvalid(r_s_tvalid), .s_axis_tlast(r_s_tlast),
    .s_axis_tready(r_s_tready),
    .m_axis_tdata(r_m_tdata), .m_axis_tvalid(r_m_tvalid), .m_axis_tlast(r_m_tlast),
    .m_axis_tready(r_m_tready), .drop_count(r_drop)
  );

  // Values applied to DUT A at the next falling edge
  logic        n_rst  = 1'b1;
  logic [15:0] n_sel  = '0;
  logic [15:0] n_mrdy = '1;

  task automatic cyc(input logic v, input logic [31:0] d, input logic l);
    @(negedge clk);
    a_rst      = n_rst;
    a_sel      = n_sel;
    a_m_tready = n_mrdy;
    a_s_tvalid = v;
    a_s_tdata  = d;
    a_s_tlast  = l;
    #1;
  endtask

  function automatic logic [31:0] lane(input int i);
    return a_m_tdata[i*32 +: 32];
  endfunction

  logic [64:0] sbq [4][$];

  initial begin
    int pkt;
    int beat;
    int len;
    logic [3:0] pmask;
    logic [64:0] e;

    // Reset values
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("rst_tvalid", 64'(a_m_tvalid), 0);
    check("rst_tlast", 64'(a_m_tlast), 0);
    check("rst_tdata_zero", 64'(a_m_tdata == '0), 1);
    check("rst_sready", 64'(a_s_tready), 1);
    check("rst_drop", 64'(a_drop), 0);

    // 3-beat packet to channel 2
    n_rst = 0; n_sel = 16'h0004; n_mrdy = '1;
    cyc(1, 32'hA, 0);
    check("p1_lat_tvalid", 64'(a_m_tvalid), 0);
    check("p1_sready", 64'(a_s_tready), 1);
    cyc(1, 32'hB, 0);
    check("p1_a_tvalid", 64'(a_m_tvalid), 64'h4);
    check("p1_a_data", 64'(lane(2)), 64'hA);
    check("p1_a_tlast", 64'(a_m_tlast), 0);
    check("p1_lane0_zero", 64'(lane(0)), 0);
    cyc(1, 32'hC, 1);
    check("p1_b_data", 64'(lane(2)), 64'hB);
    cyc(0, 0, 0);
    check("p1_c_tvalid", 64'(a_m_tvalid), 64'h4);
    check("p1_c_data", 64'(lane(2)), 64'hC);
    check("p1_c_tlast", 64'(a_m_tlast), 64'h4);
    cyc(0, 0, 0);
    check("p1_idle_tvalid", 64'(a_m_tvalid), 0);

    // Select change mid-packet is ignored; next single-beat packet uses new select
    cyc(1, 32'h11, 0);
    n_sel = 16'h0010;
    cyc(1, 32'h12, 0);
    check("p2_b1_tvalid", 64'(a_m_tvalid), 64'h4);
    check("p2_b1_data", 64'(lane(2)), 64'h11);
    cyc(1, 32'h13, 0);
    check("p2_b2_tvalid", 64'(a_m_tvalid), 64'h4);
    cyc(1, 32'h14, 1);
    check("p2_b3_tvalid", 64'(a_m_tvalid), 64'h4);
    check("p2_b3_data", 64'(lane(2)), 64'h13);
    cyc(1, 32'h21, 1);
    check("p2_b4_tvalid", 64'(a_m_tvalid), 64'h4);
    check("p2_b4_tlast", 64'(a_m_tlast), 64'h4);
    cyc(0, 0, 0);
    check("p3_tvalid", 64'(a_m_tvalid), 64'h10);
    check("p3_data", 64'(lane(4)), 64'h21);
    check("p3_tlast", 64'(a_m_tlast), 64'h10);
    cyc(0, 0, 0);

    // Broadcast with channel 1 stalled for 3 cycles
    n_sel = 16'h0003; n_mrdy = ~16'h0002;
    cyc(1, 32'h33, 1);
    check("bc_sready0", 64'(a_s_tready), 1);
    cyc(1, 32'h44, 1);
    check("bc_tvalid1", 64'(a_m_tvalid), 64'h3);
    check("bc_data1", 64'(lane(1)), 64'h33);
    check("bc_sready1", 64'(a_s_tready), 0);
    cyc(1, 32'h44, 1);
    check("bc_tvalid2", 64'(a_m_tvalid), 64'h2);
    check("bc_sready2", 64'(a_s_tready), 0);
    cyc(1, 32'h44, 1);
    check("bc_tvalid3", 64'(a_m_tvalid), 64'h2);
    check("bc_data3", 64'(lane(1)), 64'h33);
    n_mrdy = '1;
    cyc(1, 32'h44, 1);
    check("bc_tvalid4", 64'(a_m_tvalid), 64'h2);
    check("bc_sready4", 64'(a_s_tready), 1);
    cyc(0, 0, 0);
    check("bc_next_tvalid", 64'(a_m_tvalid), 64'h3);
    check("bc_next_data", 64'(lane(0)), 64'h44);
    cyc(0, 0, 0);
    check("bc_done_tvalid", 64'(a_m_tvalid), 0);

    // Empty mask: five beats dropped
    n_sel = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'h50 + i, (i != 0));
      check("drop_sready", 64'(a_s_tready), 1);
      check("drop_tvalid", 64'(a_m_tvalid), 0);
    end
    cyc(0, 0, 0);
    check("drop_tvalid_end", 64'(a_m_tvalid), 0);
    check("drop_count", 64'(a_drop), 5);

    // Reset mid-packet with a beat pending on channel 7
    n_sel = 16'h0080; n_mrdy = '0;
    cyc(1, 32'h77, 0);
    cyc(1, 32'h78, 0);
    check("mr_pend_tvalid", 64'(a_m_tvalid), 64'h80);
    check("mr_pend_sready", 64'(a_s_tready), 0);
    n_rst = 1;
    cyc(0, 0, 0);
    n_rst = 0; n_sel = 16'h0002; n_mrdy = '1;
    cyc(1, 32'h99, 1);
    check("mr_tvalid", 64'(a_m_tvalid), 0);
    check("mr_tlast", 64'(a_m_tlast), 0);
    check("mr_tdata_zero", 64'(a_m_tdata == '0), 1);
    check("mr_sready", 64'(a_s_tready), 1);
    check("mr_drop", 64'(a_drop), 0);
    cyc(0, 0, 0);
    check("mr_next_tvalid", 64'(a_m_tvalid), 64'h2);
    check("mr_next_data", 64'(lane(1)), 64'h99);
    cyc(0, 0, 0);

    // Random packets with random sink backpressure
    @(negedge clk);
    r_rst = 1'b0;
    pkt = 0; beat = 0; len = $urandom_range(1, 4); pmask = '0;
    for (int n = 0; n < 20000; n++) begin
      if (pkt == 100 && sbq[0].size() == 0 && sbq[1].size() == 0 &&
          sbq[2].size() == 0 && sbq[3].size() == 0) break;
      @(negedge clk);
      for (int c = 0; c < 4; c++) r_m_tready[c] = ($urandom_range(0, 3) != 0);
      r_sel = 4'($urandom_range(1, 15));
      if (pkt < 100) begin
        r_s_tvalid = ($urandom_range(0, 3) != 0);
        r_s_tdata  = {16'(pkt), 16'(beat), 32'($urandom())};
        r_s_tlast  = (beat == len - 1);
      end else begin
        r_s_tvalid = 1'b0;
      end
      #1;
      for (int c = 0; c < 4; c++) begin
        if (r_m_tvalid[c] && r_m_tready[c]) begin
          if (sbq[c].size() == 0) begin
            check("rnd_unexpected_beat", 64'(c), 64'hFF);
          end else begin
            e = sbq[c].pop_front();
            check("rnd_data", r_m_tdata[c*64 +: 64], e[63:0]);
            check("rnd_tlast", 64'(r_m_tlast[c]), 64'(e[64]));
          end
        end
      end
      if (r_s_tvalid && r_s_tready) begin
        if (beat == 0) pmask = r_sel;
        for (int c = 0; c < 4; c++)
          if (pmask[c]) sbq[c].push_back({r_s_tlast, r_s_tdata});
        if (r_s_tlast) begin
          pkt++;
          beat = 0;
          len = $urandom_range(1, 4);
        end else begin
          beat++;
        end
      end
    end
    check("rnd_pkts_sent", 64'(pkt), 100);
    for (int c = 0; c < 4; c++) check("rnd_leftover", 64'(sbq[c].size()), 0);
    check("rnd_drop", 64'(r_drop), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
